set_lu_frame: RTL

- Parametrised, frame-based successor to the Set-game logic unit.
- Evaluates a stream of N-bit region-coverage vectors (one per candidate board point) against a configured selection rule, then emits a registered per-point hit stream and a running hit count.
- Sits between the board/coverage scanner and the scoring/display logic.
- The old fixed 3-set, 4-mode rules are expressible as mask/K configurations.

---
 rtl/set_lu_frame_pkg.sv | 14 +
 rtl/set_lu_eval.sv | 39 +++
 rtl/set_lu_frame.sv | 91 +++++++++
 3 files changed

// File: rtl/set_lu_frame_pkg.sv
// Shared rule, state and width constants for the frame-based Set logic unit.
package set_lu_frame_pkg;

   localparam int MODE_SZ = 2;

   localparam logic [MODE_SZ-1:0] MODE_ANY       = 2'd0;
   localparam logic [MODE_SZ-1:0] MODE_ALL       = 2'd1;
   localparam logic [MODE_SZ-1:0] MODE_EXACT_K   = 2'd2;
   localparam logic [MODE_SZ-1:0] MODE_ATLEAST_K = 2'd3;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/set_lu_eval.sv
// Combinational rule evaluator: masks a coverage vector, counts the
// covered sets and applies the selected selection rule.
module set_lu_eval
   import set_lu_frame_pkg::*;
#(
   parameter int NUM_SETS = 3,
   parameter int K_W      = 2
) (
   input  logic [NUM_SETS-1:0] covered,
   input  logic [NUM_SETS-1:0] mask,
   input  logic [K_W-1:0]      k,
   input  logic [MODE_SZ-1:0]  mode,
   output logic                hit
);

   logic [NUM_SETS-1:0] m;
   logic [K_W-1:0]      p;

   assign m = covered & mask;

   always_comb begin
      p = '0;
      for (int i = 0; i < NUM_SETS; i++)
         p = p + K_W'(m[i]);
   end

   // an empty mask never satisfies ALL, even though m==mask trivially
   always_comb begin
      hit = 1'b0;
      case (mode)
         MODE_ANY:       hit = |m;
         MODE_ALL:       hit = (m == mask) && (|mask);
         MODE_EXACT_K:   hit = (p == k);
         MODE_ATLEAST_K: hit = (p >= k);
         default:        hit = 1'b0;
      endcase
   end

endmodule

// File: rtl/set_lu_frame.sv
// Frame controller: latches the rule at start, streams points through the
// evaluator and registers the hit, saturating hit count and end-of-frame pulse.
module set_lu_frame
   import set_lu_frame_pkg::*;
#(
   parameter int NUM_SETS = 3,
   parameter int CNT_W    = 8,
   parameter int K_W      = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start_i,
   input  logic [MODE_SZ-1:0]  mode_i,
   input  logic [NUM_SETS-1:0] mask_i,
   input  logic [K_W-1:0]      k_i,
   input  logic                in_valid_i,
   input  logic [NUM_SETS-1:0] covered_i,
   input  logic                in_last_i,
   output logic                in_ready_o,
   output logic                hit_valid_o,
   output logic                hit_o,
   output logic [CNT_W-1:0]    count_o,
   output logic                done_o,
   output logic                busy_o,
   output logic                cfg_err_o
);

   logic [0:0]          state;
   logic [MODE_SZ-1:0]  mode_q;
   logic [NUM_SETS-1:0] mask_q;
   logic [K_W-1:0]      k_q;
   logic                accept;
   logic                hit_d;
   logic                cfg_bad;

   assign in_ready_o = (state == ST_RUN);
   assign busy_o     = (state == ST_RUN);
   assign accept     = in_valid_i && in_ready_o;
   assign cfg_bad    = (mask_i == '0) ||
                       ({1'b0, k_i} > (K_W+1)'(NUM_SETS));

   set_lu_eval #(
      .NUM_SETS (NUM_SETS),
      .K_W      (K_W)
   ) u_eval (
      .covered (covered_i),
      .mask    (mask_q),
      .k       (k_q),
      .mode    (mode_q),
      .hit     (hit_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         mode_q      <= '0;
         mask_q      <= '0;
         k_q         <= '0;
         hit_valid_o <= 1'b0;
         hit_o       <= 1'b0;
         count_o     <= '0;
         done_o      <= 1'b0;
         cfg_err_o   <= 1'b0;
      end else begin
         hit_valid_o <= accept;
         hit_o       <= accept && hit_d;
         done_o      <= accept && in_last_i;
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  state     <= ST_RUN;
                  mode_q    <= mode_i;
                  mask_q    <= mask_i;
                  k_q       <= k_i;
                  count_o   <= '0;
                  cfg_err_o <= cfg_bad;
               end
            end
            ST_RUN: begin
               if (accept && in_last_i)
                  state <= ST_IDLE;
               // hold at all-ones rather than wrap
               if (accept && hit_d && (count_o != '1))
                  count_o <= count_o + CNT_W'(1);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
